// File: rtl/serial_com_rx.sv
// Serial-to-parallel receiver: finds byte alignment from COM symbols, locks after
// COM_COUNT aligned COMs, then delivers one byte per eight bit clocks.
module serial_com_rx #(
    parameter logic [7:0]  COM_BYTE  = 8'hBC,
    parameter logic [7:0]  IDLE_BYTE = 8'h7C,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ALIGNING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] sr;
    logic [7:0] nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [3:0] com_cnt;
    logic [3:0] com_cnt_nxt;
    logic [3:0] com_inc;
    logic [7:0] data_out_nxt;
    logic       valid_nxt;
    logic       strobe_nxt;
    logic       active_nxt;
    logic       boundary;
    logic       com_hit;
    logic       idle_hit;

    // Every compare looks at the byte as it will be once this edge's bit is shifted in.
    assign nxt      = {sr[6:0], data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign com_hit  = (nxt == COM_BYTE);
    assign idle_hit = (nxt == IDLE_BYTE);
    assign com_inc  = com_cnt + 4'd1;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state       <= UNLOCKED;
            sr          <= 8'd0;
            bit_cnt     <= 3'd0;
            com_cnt     <= 4'd0;
            data_out    <= 8'd0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= nxt;
            bit_cnt     <= bit_cnt_nxt;
            com_cnt     <= com_cnt_nxt;
            data_out    <= data_out_nxt;
            valid_out   <= valid_nxt;
            byte_strobe <= strobe_nxt;
            active      <= active_nxt;
        end
    end

    // valid_out is a one-cycle pulse with no back-pressure: the consumer must take
    // data_out in the cycle valid_out is high; data_out then holds until the next data byte.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt + 3'd1;
        com_cnt_nxt  = com_cnt;
        data_out_nxt = data_out;
        valid_nxt    = 1'b0;
        strobe_nxt   = 1'b0;
        active_nxt   = active;

        case (state)
            UNLOCKED: begin
                bit_cnt_nxt = 3'd0;
                if (com_hit) begin
                    if (COM_TARGET == 4'd1) begin
                        state_nxt   = LOCKED;
                        active_nxt  = 1'b1;
                        com_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt   = ALIGNING;
                        com_cnt_nxt = 4'd1;
                    end
                end
            end

            ALIGNING: begin
                if (boundary) begin
                    if (com_hit) begin
                        if (com_inc == COM_TARGET) begin
                            state_nxt   = LOCKED;
                            active_nxt  = 1'b1;
                            com_cnt_nxt = 4'd0;
                        end else begin
                            com_cnt_nxt = com_inc;
                        end
                    end else begin
                        // A broken COM run drops alignment; this byte is not re-examined.
                        state_nxt   = UNLOCKED;
                        com_cnt_nxt = 4'd0;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    strobe_nxt = 1'b1;
                    if (!com_hit && !idle_hit) begin
                        data_out_nxt = nxt;
                        valid_nxt    = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt   = UNLOCKED;
                bit_cnt_nxt = 3'd0;
                com_cnt_nxt = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_com_rx.sv
// Directed bench for serial_com_rx: alignment, lock timing, COM/IDLE suppression,
// asynchronous reset and realignment.
module tb_serial_com_rx;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int n_vec;
    int n_err;
    int edge_n;
    int active_edge;
    int strobe_seen;
    int valid_seen;

    serial_com_rx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        edge_n      = 0;
        active_edge = -1;
        strobe_seen = 0;
        valid_seen  = 0;
    endtask

    // Drive one bit, clock it in, then sample the outputs 1 time unit after the edge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        edge_n++;
        if (byte_strobe) strobe_seen++;
        if (valid_out) valid_seen++;
        if (active && active_edge < 0) active_edge = edge_n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        data_in = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        data_in = 1'b0;
        clear_counts();

        // Reset state
        #2;
        check_eq("rst_data_out", {24'd0, data_out}, 32'h0);
        check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("rst_strobe", {31'd0, byte_strobe}, 32'd0);
        check_eq("rst_active", {31'd0, active}, 32'd0);
        do_reset();

        // Junk 101, four COMs, then A5
        clear_counts();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (4) send_byte(8'hBC);
        check_eq("lock_edge", active_edge, 35);
        check_eq("lock_no_strobe", strobe_seen, 0);
        clear_counts();
        send_byte(8'hA5);
        check_eq("a5_valid", {31'd0, valid_out}, 32'd1);
        check_eq("a5_data", {24'd0, data_out}, 32'hA5);
        check_eq("a5_strobe", {31'd0, byte_strobe}, 32'd1);
        check_eq("a5_valid_count", valid_seen, 1);

        // IDLE and COM are strobed but not delivered
        clear_counts();
        send_byte(8'h7C);
        check_eq("idle_valid_count", valid_seen, 0);
        check_eq("idle_data_hold", {24'd0, data_out}, 32'hA5);
        send_byte(8'hBC);
        check_eq("com_valid_count", valid_seen, 0);
        check_eq("com_data_hold", {24'd0, data_out}, 32'hA5);
        send_byte(8'h3C);
        check_eq("3c_valid", {31'd0, valid_out}, 32'd1);
        check_eq("3c_data", {24'd0, data_out}, 32'h3C);
        check_eq("strobe_count_3", strobe_seen, 3);
        check_eq("valid_count_3", valid_seen, 1);

        // COM pattern straddling a boundary is ignored
        clear_counts();
        send_byte(8'h0B);
        check_eq("0b_valid", {31'd0, valid_out}, 32'd1);
        check_eq("0b_data", {24'd0, data_out}, 32'h0B);
        send_byte(8'hC0);
        check_eq("c0_valid", {31'd0, valid_out}, 32'd1);
        check_eq("c0_data", {24'd0, data_out}, 32'hC0);
        check_eq("c0_strobe", {31'd0, byte_strobe}, 32'd1);
        check_eq("straddle_valid_count", valid_seen, 2);
        check_eq("straddle_active", {31'd0, active}, 32'd1);

        // Mid-byte asynchronous reset with random data
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_data_out", {24'd0, data_out}, 32'h0);
        check_eq("async_valid", {31'd0, valid_out}, 32'd0);
        check_eq("async_strobe", {31'd0, byte_strobe}, 32'd0);
        check_eq("async_active", {31'd0, active}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
        end
        #1;
        check_eq("hold_active", {31'd0, active}, 32'd0);
        reset = 1'b1;

        // Only three COMs after reset: no lock
        clear_counts();
        repeat (3) send_byte(8'hBC);
        send_byte(8'hA5);
        check_eq("relock_active", {31'd0, active}, 32'd0);
        check_eq("relock_edge", active_edge, -1);
        check_eq("relock_valid_count", valid_seen, 0);
        check_eq("relock_strobe_count", strobe_seen, 0);

        // Broken COM run, then four fresh COMs
        do_reset();
        clear_counts();
        repeat (3) send_byte(8'hBC);
        send_byte(8'h55);
        check_eq("broken_active", {31'd0, active}, 32'd0);
        repeat (4) send_byte(8'hBC);
        check_eq("broken_lock_edge", active_edge, 64);
        send_byte(8'h96);
        check_eq("post_lock_data", {24'd0, data_out}, 32'h96);
        check_eq("post_lock_valid_count", valid_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
